// File: rtl/apb_uart_master.sv
// ---------------------------------------------------------------------------
// apb_uart_master
//
// Command-driven APB master placed in front of the APB UART peripheral
// (data 0x400, state 0x404, ctrl 0x408, baud 0x410). Requests are queued in
// a small command FIFO and each one is issued as a single SETUP + ACCESS
// transfer. A PREADY timeout aborts a stalled ACCESS phase. Every finished
// or aborted transfer yields one registered response pulse.
//
// Parameters
//   FIFO_DEPTH  command FIFO entries (power of two, >= 2)
//   TIMEOUT     maximum ACCESS-phase cycles per transfer (1..255)
//
// Ports
//   PCLK, PRESET          clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (cmd_ready = FIFO not full)
//   cmd_write/addr/wdata  command payload (wdata ignored for reads)
//   rsp_valid             one-cycle pulse per completed/aborted transfer
//   rsp_rdata, rsp_err    response payload, held until the next response
//   fifo_level            number of queued (not yet issued) commands
//   busy                  FSM active or commands queued
//   PSEL..PRDATA          APB master interface
// ---------------------------------------------------------------------------
module apb_uart_master #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  TIMEOUT    = 8'd255
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [11:0]                   cmd_addr,
    input  logic [7:0]                    cmd_wdata,
    output logic                          rsp_valid,
    output logic [31:0]                   rsp_rdata,
    output logic                          rsp_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [11:0]                   PADDR,
    output logic [7:0]                    PWDATA,
    input  logic                          PREADY,
    input  logic [31:0]                   PRDATA
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LEVEL_W = PTR_W + 1;

    typedef struct packed {
        logic        write;
        logic [11:0] addr;
        logic [7:0]  wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t state, next_state;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    cmd_t               mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LEVEL_W-1:0] count;
    logic               push, pop, fifo_empty;
    cmd_t               head;

    assign fifo_empty = (count == '0);
    // Full blocks a push even when a pop happens in the same cycle.
    assign cmd_ready  = (count != LEVEL_W'(FIFO_DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign head       = mem[rd_ptr];
    assign fifo_level = count;

    // NOTE: storage array has no reset; the pointers and count define which
    // entries are valid, so clearing the payload would only cost a reset net.
    always_ff @(posedge PCLK) begin
        if (push) begin
            mem[wr_ptr] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    logic [7:0]  tmo_cnt;
    logic        xfer_done, xfer_abort;
    logic        write_q;
    logic [11:0] addr_q;
    logic [7:0]  wdata_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        xfer_done  = 1'b0;
        xfer_abort = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = SETUP;
                end
            end
            SETUP: begin
                next_state = ACCESS;
            end
            ACCESS: begin
                if (PREADY)                              xfer_done  = 1'b1;
                else if (tmo_cnt == (TIMEOUT - 8'd1))    xfer_abort = 1'b1;
                // Finished transfers chain straight into the next SETUP so a
                // busy queue keeps PSEL asserted without an IDLE bubble.
                if (xfer_done || xfer_abort) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        next_state = SETUP;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Transfer registers, timeout counter and response registers.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tmo_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= xfer_done || xfer_abort;
            if (xfer_done) begin
                rsp_rdata <= write_q ? 32'd0 : PRDATA;
                rsp_err   <= 1'b0;
            end else if (xfer_abort) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end

            if (pop) begin
                write_q <= head.write;
                addr_q  <= head.addr;
                wdata_q <= head.write ? head.wdata : 8'd0;
                tmo_cnt <= '0;
            end else if (state == ACCESS && !PREADY) begin
                // Cannot wrap: the abort fires at TIMEOUT-1 (<= 254).
                tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end

    // APB outputs are derived from the state register so they fall as soon
    // as reset is applied, and read as zero while idle.
    logic in_xfer;
    assign in_xfer = (state != IDLE);
    assign PSEL    = in_xfer;
    assign PENABLE = (state == ACCESS);
    assign PWRITE  = in_xfer ? write_q : 1'b0;
    assign PADDR   = in_xfer ? addr_q  : 12'd0;
    assign PWDATA  = in_xfer ? wdata_q : 8'd0;
    assign busy    = in_xfer || !fifo_empty;

endmodule

// File: tb/tb_apb_uart_master.sv
// ---------------------------------------------------------------------------
// tb_apb_uart_master
//
// Self-checking bench for apb_uart_master (FIFO_DEPTH=4, TIMEOUT=16).
// All stimulus is driven and all outputs are sampled on the falling clock
// edge. Directed scenarios cover reset, latency, wait states, FIFO
// capacity/back-to-back and timeout; a randomized scenario checks ordering,
// response contents, FIFO occupancy and address stability against a
// transaction-level model.
// ---------------------------------------------------------------------------
module tb_apb_uart_master;

    localparam int         FIFO_DEPTH = 4;
    localparam int         TMO        = 16;
    localparam logic [7:0] TIMEOUT    = 8'd16;
    localparam int         N_RAND     = 40;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [11:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [2:0]  fifo_level;
    logic        busy;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [11:0] PADDR;
    logic [7:0]  PWDATA;
    logic        PREADY;
    logic [31:0] PRDATA;

    int checks   = 0;
    int failures = 0;

    always #5 PCLK = ~PCLK;

    apb_uart_master #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .fifo_level (fifo_level),
        .busy       (busy),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PREADY     (PREADY),
        .PRDATA     (PRDATA)
    );

    // Advance one clock: through the rising edge to the next falling edge.
    task automatic step();
        @(posedge PCLK);
        @(negedge PCLK);
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 12'd0;
        cmd_wdata = 8'd0;
    endtask

    task automatic offer(input logic w, input logic [11:0] a, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        PRESET = 1'b1;
        step();
        checks++; if (PSEL !== 1'b0)        begin failures++; $display("FAIL rst_psel: got %b expected 0", PSEL); end
        checks++; if (PENABLE !== 1'b0)     begin failures++; $display("FAIL rst_penable: got %b expected 0", PENABLE); end
        checks++; if (rsp_valid !== 1'b0)   begin failures++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (cmd_ready !== 1'b1)   begin failures++; $display("FAIL rst_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if (fifo_level !== 3'd0)  begin failures++; $display("FAIL rst_level: got %0d expected 0", fifo_level); end
        checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0 || PADDR !== 12'd0 || PWDATA !== 8'd0 || PWRITE !== 1'b0)
            begin failures++; $display("FAIL rst_outputs: rdata=%h err=%b paddr=%h pwdata=%h pwrite=%b expected all 0",
                                       rsp_rdata, rsp_err, PADDR, PWDATA, PWRITE); end
        step();
        PRESET = 1'b0;
        step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_write();
        PREADY = 1'b1;
        PRDATA = $urandom | 32'h1;
        offer(1'b1, 12'h400, 8'hD8);
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL wr_ready: got %b expected 1", cmd_ready); end
        step();                                   // edge k: accepted
        idle_inputs();
        checks++; if (fifo_level !== 3'd1 || busy !== 1'b1 || PSEL !== 1'b0)
            begin failures++; $display("FAIL wr_queued: level=%0d busy=%b psel=%b expected 1/1/0", fifo_level, busy, PSEL); end
        step();                                   // edge k+1: SETUP
        checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0)
            begin failures++; $display("FAIL wr_setup: psel=%b penable=%b expected 1/0", PSEL, PENABLE); end
        checks++; if (PADDR !== 12'h400 || PWRITE !== 1'b1 || PWDATA !== 8'hD8)
            begin failures++; $display("FAIL wr_setup_bus: paddr=%h pwrite=%b pwdata=%h expected 400/1/d8", PADDR, PWRITE, PWDATA); end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL wr_pop: got %0d expected 0", fifo_level); end
        step();                                   // edge k+2: ACCESS
        checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b1 || PADDR !== 12'h400 || PWRITE !== 1'b1 || PWDATA !== 8'hD8 || rsp_valid !== 1'b0)
            begin failures++; $display("FAIL wr_access: psel=%b pen=%b paddr=%h pwrite=%b pwdata=%h rsp=%b expected 1/1/400/1/d8/0",
                                       PSEL, PENABLE, PADDR, PWRITE, PWDATA, rsp_valid); end
        step();                                   // edge k+3: complete
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0)
            begin failures++; $display("FAIL wr_rsp: valid=%b rdata=%h err=%b expected 1/0/0", rsp_valid, rsp_rdata, rsp_err); end
        checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || PADDR !== 12'd0)
            begin failures++; $display("FAIL wr_idle_bus: psel=%b pen=%b paddr=%h expected 0/0/0", PSEL, PENABLE, PADDR); end
        step();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0)
            begin failures++; $display("FAIL wr_pulse: valid=%b busy=%b expected 0/0", rsp_valid, busy); end
        PREADY = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_read_wait();
        int acc;
        PREADY = 1'b0;
        offer(1'b0, 12'h404, 8'($urandom_range(1, 255)));
        step();
        idle_inputs();
        step();                                   // SETUP
        checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PWRITE !== 1'b0 || PWDATA !== 8'd0)
            begin failures++; $display("FAIL rd_setup: psel=%b pen=%b pwrite=%b pwdata=%h expected 1/0/0/00", PSEL, PENABLE, PWRITE, PWDATA); end
        acc = 0;
        for (int i = 0; i < 24 && !rsp_valid; i++) begin
            PREADY = 1'b0;
            PRDATA = $urandom;
            if (PSEL && PENABLE) begin
                acc++;
                checks++; if (PADDR !== 12'h404 || PWRITE !== 1'b0 || PWDATA !== 8'd0)
                    begin failures++; $display("FAIL rd_stable: paddr=%h pwrite=%b pwdata=%h expected 404/0/00", PADDR, PWRITE, PWDATA); end
                if (acc == 4) begin
                    PREADY = 1'b1;
                    PRDATA = 32'h0000_0003;
                end
            end
            step();
        end
        PREADY = 1'b0;
        PRDATA = $urandom;
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rd_rsp_valid: got %b expected 1", rsp_valid); end
        checks++; if (acc !== 4) begin failures++; $display("FAIL rd_access_len: got %0d expected 4", acc); end
        checks++; if (rsp_rdata !== 32'h3 || rsp_err !== 1'b0)
            begin failures++; $display("FAIL rd_rsp: rdata=%h err=%b expected 00000003/0", rsp_rdata, rsp_err); end
        step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_timeout();
        int acc;
        PREADY = 1'b0;
        offer(1'b0, 12'h410, 8'h00);
        step();
        idle_inputs();
        acc = 0;
        for (int i = 0; i < 40 && !rsp_valid; i++) begin
            PRDATA = $urandom | 32'h8000_0000;
            if (PSEL && PENABLE) acc++;
            step();
        end
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL tmo_rsp_valid: got %b expected 1", rsp_valid); end
        checks++; if (acc !== TMO) begin failures++; $display("FAIL tmo_access_len: got %0d expected %0d", acc, TMO); end
        checks++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'd0)
            begin failures++; $display("FAIL tmo_rsp: err=%b rdata=%h expected 1/0", rsp_err, rsp_rdata); end
        checks++; if (PSEL !== 1'b0 || busy !== 1'b0)
            begin failures++; $display("FAIL tmo_idle: psel=%b busy=%b expected 0/0", PSEL, busy); end
        step();
        checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b1)
            begin failures++; $display("FAIL tmo_hold: valid=%b err=%b expected 0/1", rsp_valid, rsp_err); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [7:0] data [6];
        logic [7:0] seen [$];
        int  sent, nrsp, last_c;
        bit  rdy;
        data = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h21};
        seen.delete();
        sent   = 0;
        PREADY = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (sent < 6) offer(1'b1, 12'h400, data[sent]);
            else          idle_inputs();
            rdy = cmd_ready;
            step();
            if (sent < 6 && rdy) sent++;
        end
        checks++; if (sent !== 5) begin failures++; $display("FAIL b2b_accepted: got %0d expected 5", sent); end
        checks++; if (cmd_ready !== 1'b0 || fifo_level !== 3'd4)
            begin failures++; $display("FAIL b2b_full: ready=%b level=%0d expected 0/4", cmd_ready, fifo_level); end

        PREADY = 1'b1;
        nrsp   = 0;
        last_c = 0;
        for (int c = 0; c < 40 && nrsp < 6; c++) begin
            if (PSEL && PENABLE) seen.push_back(PWDATA);
            if (rsp_valid) begin
                checks++; if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0)
                    begin failures++; $display("FAIL b2b_rsp%0d: rdata=%h err=%b expected 0/0", nrsp, rsp_rdata, rsp_err); end
                if (nrsp > 0) begin
                    checks++; if (c - last_c !== 2)
                        begin failures++; $display("FAIL b2b_spacing%0d: got %0d expected 2", nrsp, c - last_c); end
                end
                last_c = c;
                nrsp++;
            end
            if (nrsp > 0 && nrsp < 6) begin
                checks++; if (PSEL !== 1'b1) begin failures++; $display("FAIL b2b_psel_gap: got %b expected 1", PSEL); end
            end
            if (sent < 6) offer(1'b1, 12'h400, data[sent]);
            else          idle_inputs();
            rdy = cmd_ready;
            step();
            if (sent < 6 && rdy) sent++;
        end
        idle_inputs();
        PREADY = 1'b0;
        checks++; if (nrsp !== 6 || sent !== 6)
            begin failures++; $display("FAIL b2b_count: rsp=%0d sent=%0d expected 6/6", nrsp, sent); end
        checks++; if (seen.size() !== 6)
            begin failures++; $display("FAIL b2b_xfers: got %0d expected 6", seen.size()); end
        for (int i = 0; i < 6 && i < seen.size(); i++) begin
            checks++; if (seen[i] !== data[i])
                begin failures++; $display("FAIL b2b_order%0d: got %h expected %h", i, seen[i], data[i]); end
        end
        step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        int ghosts;
        logic [31:0] rd;
        PREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(1'b0, 12'($urandom), 8'($urandom));
            step();
        end
        idle_inputs();
        checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b1 || fifo_level !== 3'd2)
            begin failures++; $display("FAIL rmid_pre: psel=%b pen=%b level=%0d expected 1/1/2", PSEL, PENABLE, fifo_level); end
        PRESET = 1'b1;
        #1;
        checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== 1'b0)
            begin failures++; $display("FAIL rmid_async_bus: psel=%b pen=%b rsp=%b expected 0/0/0", PSEL, PENABLE, rsp_valid); end
        checks++; if (cmd_ready !== 1'b1 || fifo_level !== 3'd0 || busy !== 1'b0)
            begin failures++; $display("FAIL rmid_async_fifo: ready=%b level=%0d busy=%b expected 1/0/0", cmd_ready, fifo_level, busy); end
        step();
        PRESET = 1'b0;
        PREADY = 1'b1;
        ghosts = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid || PSEL) ghosts++;
            step();
        end
        checks++; if (ghosts !== 0) begin failures++; $display("FAIL rmid_ghost: got %0d cycles expected 0", ghosts); end

        rd     = $urandom;
        PRDATA = rd;
        offer(1'b0, 12'h408, 8'h00);
        step();
        idle_inputs();
        step();
        step();
        checks++; if (PENABLE !== 1'b1 || PADDR !== 12'h408)
            begin failures++; $display("FAIL rmid_fresh_access: pen=%b paddr=%h expected 1/408", PENABLE, PADDR); end
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== 1'b0)
            begin failures++; $display("FAIL rmid_fresh_rsp: valid=%b rdata=%h err=%b expected 1/%h/0", rsp_valid, rsp_rdata, rsp_err, rd); end
        PREADY = 1'b0;
        step();
    endtask

    // ------------------------------------------------------------------
    // Randomized traffic. The model is transaction-level: commands are
    // served strictly in order, the i-th transfer waits r_wait[i] ACCESS
    // cycles before PREADY, anything waiting TMO or more cycles is aborted,
    // and queued entries equal accepted commands minus started transfers.
    task automatic test_random();
        logic        r_write [N_RAND];
        logic [11:0] r_addr  [N_RAND];
        logic [7:0]  r_wdata [N_RAND];
        int          r_wait  [N_RAND];
        logic [31:0] r_rdata [N_RAND];
        logic [11:0] regs [4];
        int  issued, t, acc_n, nrsp, cyc, exp_lvl, sel;
        bit  offered, rdy, exp_err;
        logic [31:0] exp_data;
        regs = '{12'h400, 12'h404, 12'h408, 12'h410};
        for (int i = 0; i < N_RAND; i++) begin
            r_write[i] = 1'($urandom_range(0, 1));
            r_addr[i]  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : regs[$urandom_range(0, 3)];
            r_wdata[i] = 8'($urandom);
            r_rdata[i] = $urandom;
            sel        = int'($urandom_range(0, 9));
            r_wait[i]  = (sel < 7) ? int'($urandom_range(0, 3)) : (sel == 7) ? TMO - 1 : TMO;
        end
        issued = 0;
        t      = -1;
        acc_n  = 0;
        nrsp   = 0;
        cyc    = 0;
        PREADY = 1'b0;
        while (nrsp < N_RAND && cyc < 4000) begin
            if (rsp_valid && nrsp < N_RAND) begin
                exp_err  = (r_wait[nrsp] >= TMO);
                exp_data = (exp_err || r_write[nrsp]) ? 32'd0 : r_rdata[nrsp];
                checks++; if (rsp_err !== exp_err || rsp_rdata !== exp_data)
                    begin failures++; $display("FAIL rnd_rsp%0d: rdata=%h err=%b expected %h/%b", nrsp, rsp_rdata, rsp_err, exp_data, exp_err); end
                nrsp++;
            end

            PREADY = 1'b0;
            PRDATA = $urandom;
            if (PSEL && !PENABLE) begin
                t++;
                acc_n = 0;
                if (t < N_RAND) begin
                    checks++; if (PADDR !== r_addr[t] || PWRITE !== r_write[t] || PWDATA !== (r_write[t] ? r_wdata[t] : 8'd0))
                        begin failures++; $display("FAIL rnd_setup%0d: paddr=%h pwrite=%b pwdata=%h expected %h/%b/%h", t, PADDR, PWRITE, PWDATA,
                                                   r_addr[t], r_write[t], r_write[t] ? r_wdata[t] : 8'd0); end
                end
            end else if (PSEL && PENABLE && t >= 0 && t < N_RAND) begin
                checks++; if (PADDR !== r_addr[t] || PWRITE !== r_write[t])
                    begin failures++; $display("FAIL rnd_stable%0d: paddr=%h pwrite=%b expected %h/%b", t, PADDR, PWRITE, r_addr[t], r_write[t]); end
                if (acc_n >= r_wait[t]) begin
                    PREADY = 1'b1;
                    PRDATA = r_rdata[t];
                end
                acc_n++;
            end

            exp_lvl = issued - (t + 1);
            checks++; if (int'(fifo_level) !== exp_lvl || cmd_ready !== (exp_lvl < FIFO_DEPTH))
                begin failures++; $display("FAIL rnd_level: level=%0d ready=%b expected %0d/%b", fifo_level, cmd_ready, exp_lvl, exp_lvl < FIFO_DEPTH); end

            offered = (issued < N_RAND) && ($urandom_range(0, 3) != 0);
            if (offered) offer(r_write[issued], r_addr[issued], r_wdata[issued]);
            else         idle_inputs();
            rdy = cmd_ready;
            step();
            cyc++;
            if (offered && rdy) issued++;
        end
        idle_inputs();
        PREADY = 1'b0;
        checks++; if (nrsp !== N_RAND || t !== N_RAND - 1)
            begin failures++; $display("FAIL rnd_complete: rsp=%0d xfers=%0d expected %0d/%0d", nrsp, t + 1, N_RAND, N_RAND); end
        step();
        step();
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0)
            begin failures++; $display("FAIL rnd_drain: busy=%b rsp=%b expected 0/0", busy, rsp_valid); end
    endtask

    initial begin
        idle_inputs();
        PREADY = 1'b0;
        PRDATA = 32'd0;
        PRESET = 1'b1;
        @(negedge PCLK);
        test_reset();
        test_single_write();
        test_read_wait();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
